// File: rtl/svc_uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter and its round-robin picker.
package svc_uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic [7:0] UART_EOL = 8'h0A;

  // Index width that stays legal for degenerate single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/svc_rr_arb.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping.
module svc_rr_arb
  import svc_uart_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]          above_last;
  logic [N-1:0]          hi_req;
  logic [N-1:0]          pick_vec;
  logic [N-1:0]          pick_oh;
  logic [IW-1:0][N-1:0]  idx_cols;

  // Requests strictly above 'last' take precedence; otherwise wrap to the bottom.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign above_last[gi] = (IW'(gi) > last);
  end

  assign hi_req   = req & above_last;
  assign pick_vec = (|hi_req) ? hi_req : req;
  assign pick_oh  = pick_vec & (~pick_vec + ONE);
  assign any      = |req;

  for (genvar gb = 0; gb < IW; gb++) begin : g_enc_bit
    for (genvar gi = 0; gi < N; gi++) begin : g_enc_pos
      assign idx_cols[gb][gi] = pick_oh[gi] & (((gi >> gb) & 1) == 1);
    end
    assign idx[gb] = |idx_cols[gb];
  end

endmodule

// File: rtl/svc_uart_tx_arb.sv
// Line-atomic round-robin arbiter sharing one UART TX byte stream between N_REQ sources.
module svc_uart_tx_arb
  import svc_uart_arb_pkg::*;
#(
  parameter  int         N_REQ     = 2,
  parameter  int         MAX_BURST = 128,
  parameter  int         IDLE_TO   = 1024,
  parameter  logic [7:0] EOL_BYTE  = UART_EOL,
  localparam int         IW        = idx_w(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      s_valid,
  input  logic [N_REQ-1:0][7:0] s_data,
  output logic [N_REQ-1:0]      s_ready,
  output logic                  m_valid,
  output logic [7:0]            m_data,
  input  logic                  m_ready,
  output logic                  grant_valid,
  output logic [IW-1:0]         grant_idx
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TO + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;

  logic                  arb_any;
  logic [IW-1:0]         arb_idx;
  logic                  locked;
  logic [N_REQ-1:0]      grant_oh;
  logic [N_REQ:0][7:0]   data_chain;
  logic                  xfer;
  logic [BW-1:0]         burst_inc;
  logic                  rel_now;

  svc_rr_arb #(.N(N_REQ)) u_rr (
    .req  (s_valid),
    .last (last_q),
    .any  (arb_any),
    .idx  (arb_idx)
  );

  assign locked = (state_q == LOCKED);

  // The data path is an AND-OR mux keyed by the registered grant, so it is all zero in IDLE.
  assign data_chain[0] = 8'h00;
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_route
    assign grant_oh[gi]       = locked && (grant_q == IW'(gi));
    assign data_chain[gi + 1] = data_chain[gi] | (s_data[gi] & {8{grant_oh[gi]}});
  end

  assign m_valid     = |(grant_oh & s_valid);
  assign m_data      = data_chain[N_REQ];
  assign s_ready     = grant_oh & {N_REQ{m_ready}};
  assign grant_valid = locked;
  assign grant_idx   = grant_q;

  assign xfer      = m_valid && m_ready;
  assign burst_inc = burst_cnt_q + BW'(1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    rel_now     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer) begin
          burst_cnt_d = burst_inc;
          idle_cnt_d  = '0;
          rel_now     = (m_data == EOL_BYTE) || (burst_inc == BW'(MAX_BURST));
        end else if (idle_cnt_q == TW'(IDLE_TO - 1)) begin
          rel_now = 1'b1;
        end else if (idle_cnt_q != TW'(IDLE_TO)) begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
        if (rel_now) begin
          state_d     = IDLE;
          last_d      = grant_q;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= IW'(N_REQ - 1);
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_svc_uart_tx_arb.sv
// Directed bench for svc_uart_tx_arb: per-requester byte feeders plus an ordered byte scoreboard.
module tb_svc_uart_tx_arb;

  logic            clk;
  logic            rst;
  logic [1:0]      s_valid;
  logic [1:0][7:0] s_data;
  logic [1:0]      s_ready;
  logic            m_valid;
  logic [7:0]      m_data;
  logic            m_ready;
  logic            grant_valid;
  logic [0:0]      grant_idx;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] txq0[$];
  logic [7:0] txq1[$];
  logic [8:0] sb[$];
  logic [1:0] hold;
  logic [1:0] acc;

  svc_uart_tx_arb #(
    .N_REQ     (2),
    .MAX_BURST (4),
    .IDLE_TO   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    s_valid[0] = (txq0.size() > 0) && !hold[0];
    s_valid[1] = (txq1.size() > 0) && !hold[1];
    s_data[0]  = (txq0.size() > 0) ? txq0[0] : 8'h00;
    s_data[1]  = (txq1.size() > 0) ? txq1[0] : 8'h00;
  endtask

  task automatic feed(input int r, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (r == 0) txq0.push_back(s[i]);
      else        txq1.push_back(s[i]);
    end
  endtask

  task automatic expect_line(input int r, input string s);
    for (int i = 0; i < s.len(); i++) sb.push_back({1'(r), s[i]});
  endtask

  // One clock: check the handshake at negedge, then advance the feeders after posedge.
  task automatic tick();
    logic [8:0] e;
    logic [7:0] tmp;
    @(negedge clk);
    acc = s_valid & s_ready;
    if (m_valid && m_ready) begin
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_underflow: observed byte 0x%0h from req %0d expected no transfer", m_data, grant_idx);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_byte", {23'd0, grant_idx, m_data}, {23'd0, e});
      end
    end
    @(posedge clk);
    #1;
    if (acc[0] && txq0.size() > 0) tmp = txq0.pop_front();
    if (acc[1] && txq1.size() > 0) tmp = txq1.pop_front();
    refresh();
    #1;
  endtask

  task automatic run_lines(input string tag, input int exp_cycles);
    int cnt;
    cnt = 0;
    while (sb.size() > 0 && cnt < 60) begin
      tick();
      cnt++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
    chk({tag, "_cycles"}, cnt, exp_cycles);
  endtask

  task automatic idle_release(input string tag);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk({tag, "_held"}, grant_valid, 1);
      chk({tag, "_mvalid"}, m_valid, 0);
    end
    tick();
    chk({tag, "_released"}, grant_valid, 0);
  endtask

  initial begin
    rst     = 1'b1;
    m_ready = 1'b1;
    hold    = 2'b00;
    acc     = 2'b00;
    s_valid = 2'b00;
    s_data  = '0;
    tick();
    tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_idx", grant_idx, 0);
    rst = 1'b0;

    // Single line "hi\n" from req0.
    feed(0, "hi\n");
    expect_line(0, "hi\n");
    refresh();
    #1;
    chk("hi_arb_latency", grant_valid, 0);
    tick();
    chk("hi_grant_valid", grant_valid, 1);
    chk("hi_grant_idx", grant_idx, 0);
    chk("hi_first_byte", m_data, 8'h68);
    chk("hi_s_ready", s_ready, 2'b01);
    run_lines("hi", 3);
    chk("hi_idle_after_eol", grant_valid, 0);

    // Two competing lines each: last holder was req0, so req1 goes first and they alternate.
    feed(0, "ab\nef\n");
    feed(1, "cd\ngh\n");
    expect_line(1, "cd\n");
    expect_line(0, "ab\n");
    expect_line(1, "gh\n");
    expect_line(0, "ef\n");
    refresh();
    run_lines("alt", 16);

    // Burst limit: req1 streams 6 bytes without EOL, req0 waits with "x\n".
    for (int i = 1; i <= 6; i++) txq1.push_back(8'(i));
    feed(0, "x\n");
    for (int i = 1; i <= 4; i++) sb.push_back({1'b1, 8'(i)});
    expect_line(0, "x\n");
    for (int i = 5; i <= 6; i++) sb.push_back({1'b1, 8'(i)});
    refresh();
    run_lines("burst", 11);
    idle_release("burst_tail");

    // Idle timeout: req0 sends one byte then drops s_valid mid-line.
    feed(0, "pq\n");
    expect_line(0, "pq\n");
    refresh();
    tick();
    chk("to_grant_idx", grant_idx, 0);
    tick();
    hold[0] = 1'b1;
    refresh();
    #1;
    idle_release("timeout");
    hold[0] = 1'b0;
    refresh();
    run_lines("relock", 3);

    // Back-pressure: m_ready low for 5 cycles mid-line must not release the grant.
    feed(0, "uvw\n");
    expect_line(0, "uvw\n");
    refresh();
    tick();
    tick();
    m_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", m_data, 8'h76);
      chk("stall_mvalid", m_valid, 1);
      chk("stall_grant", grant_valid, 1);
      chk("stall_s_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    run_lines("stall", 3);

    // Reset while req1 holds the line; the partial line is abandoned.
    feed(1, "AB\n");
    feed(0, "CD\n");
    expect_line(1, "A");
    refresh();
    tick();
    chk("pre_rst_grant_idx", grant_idx, 1);
    tick();
    chk("pre_rst_drain", sb.size(), 0);
    rst = 1'b1;
    txq0.delete();
    txq1.delete();
    sb.delete();
    refresh();
    #1;
    tick();
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_grant_valid", grant_valid, 0);
    chk("mid_rst_grant_idx", grant_idx, 0);
    rst = 1'b0;
    feed(0, "0\n");
    feed(1, "1\n");
    expect_line(0, "0\n");
    expect_line(1, "1\n");
    refresh();
    tick();
    chk("post_rst_grant_valid", grant_valid, 1);
    chk("post_rst_grant_idx", grant_idx, 0);
    run_lines("post_rst", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
